// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter: master drives controls, slave owns count and flags.
interface param_updown_counter_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             en;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_flags;
  logic [WIDTH-1:0] counter;
  logic             bound_pulse;
  logic             ovf_flag;
  logic             udf_flag;

  modport master (
    output en, up_down, load, load_val, clr_flags,
    input  counter, bound_pulse, ovf_flag, udf_flag
  );

  modport slave (
    input  en, up_down, load, load_val, clr_flags,
    output counter, bound_pulse, ovf_flag, udf_flag
  );
endinterface

// File: rtl/param_updown_counter.sv
// Up/down counter over 0..MAX_VAL with configurable step, wrap or saturate at the
// limits, a one-cycle boundary pulse and sticky overflow/underflow flags.
module param_updown_counter #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(1),
  parameter bit               SATURATE = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  param_updown_counter_if.slave bus
);

  // One extra bit so counter+STEP and counter+MAX_VAL+1 never overflow.
  localparam int unsigned    EW       = WIDTH + 1;
  localparam logic [EW-1:0]  MAX_EXT  = {1'b0, MAX_VAL};
  localparam logic [EW-1:0]  STEP_EXT = {1'b0, STEP};
  localparam logic [EW-1:0]  MOD_EXT  = MAX_EXT + EW'(1);

  logic [EW-1:0]    cnt_ext;
  logic [EW-1:0]    sum_up;
  logic [WIDTH-1:0] cnt_nxt;
  logic             evt_up;
  logic             evt_dn;
  logic             ovf_nxt;
  logic             udf_nxt;

  // Next count and boundary events: load beats enable beats hold.
  always_comb begin
    cnt_ext = {1'b0, bus.counter};
    sum_up  = cnt_ext + STEP_EXT;
    cnt_nxt = bus.counter;
    evt_up  = 1'b0;
    evt_dn  = 1'b0;
    if (bus.load) begin
      cnt_nxt = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_down) begin
        if (sum_up > MAX_EXT) begin
          evt_up  = 1'b1;
          cnt_nxt = SATURATE ? MAX_VAL : WIDTH'(sum_up - MOD_EXT);
        end else begin
          cnt_nxt = WIDTH'(sum_up);
        end
      end else begin
        if (cnt_ext < STEP_EXT) begin
          evt_dn  = 1'b1;
          cnt_nxt = SATURATE ? '0 : WIDTH'(cnt_ext + MOD_EXT - STEP_EXT);
        end else begin
          cnt_nxt = WIDTH'(cnt_ext - STEP_EXT);
        end
      end
    end
    // A same-cycle boundary event overrides the clear for its own flag.
    ovf_nxt = evt_up | (bus.ovf_flag & ~bus.clr_flags);
    udf_nxt = evt_dn | (bus.udf_flag & ~bus.clr_flags);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.counter     <= '0;
      bus.bound_pulse <= 1'b0;
      bus.ovf_flag    <= 1'b0;
      bus.udf_flag    <= 1'b0;
    end else begin
      bus.counter     <= cnt_nxt;
      bus.bound_pulse <= evt_up | evt_dn;
      bus.ovf_flag    <= ovf_nxt;
      bus.udf_flag    <= udf_nxt;
    end
  end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 The block SHALL provide parameter MAX_VAL, default 2**WIDTH-1, highest count value; count range is 0..MAX_VAL (legal range 1..2**WIDTH-1).
REQ-003 The block SHALL provide parameter STEP, default 1, increment/decrement magnitude (legal range 1..MAX_VAL).
REQ-004 The block SHALL provide parameter SATURATE, default 0, boundary mode: 0 = wrap, 1 = saturate.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-007 en  input  1  count enable; 1 = step this cycle.
REQ-008 up_down  input  1  direction; 1 = count up, 0 = count down.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  WIDTH  value loaded when load=1.
REQ-011 clr_flags  input  1  synchronous clear of sticky flags.
REQ-012 counter  output  WIDTH  current count, registered.
REQ-013 bound_pulse  output  1  registered one-cycle pulse: a count step crossed a boundary.
REQ-014 ovf_flag  output  1  sticky; set by any upward boundary crossing.
REQ-015 udf_flag  output  1  sticky; set by any downward boundary crossing.

Function
REQ-016 Per-cycle priority SHALL be: load, then en, then hold.
REQ-017 load=1: counter <= min(load_val, MAX_VAL); no flag change, bound_pulse=0, regardless of en/up_down.
REQ-018 load=0, en=0: counter, ovf_flag and udf_flag hold; bound_pulse=0.
REQ-019 Up step, counter+STEP <= MAX_VAL: counter <= counter+STEP; no boundary event.
REQ-020 Up step, counter+STEP > MAX_VAL, SATURATE=0: counter <= counter+STEP-(MAX_VAL+1); boundary event, sets ovf_flag.
REQ-021 Up step, counter+STEP > MAX_VAL, SATURATE=1: counter <= MAX_VAL; boundary event, sets ovf_flag.
REQ-022 Down step, counter >= STEP: counter <= counter-STEP; no boundary event.
REQ-023 Down step, counter < STEP, SATURATE=0: counter <= counter+(MAX_VAL+1)-STEP; boundary event, sets udf_flag.
REQ-024 Down step, counter < STEP, SATURATE=1: counter <= 0; boundary event, sets udf_flag.
REQ-025 Saturate mode holding at a limit (counter=MAX_VAL up, or 0 down) SHALL still count as a boundary event every enabled cycle.
REQ-026 Boundary arithmetic SHALL use WIDTH+1 bits internally; no intermediate overflow for any legal parameter set.
REQ-027 bound_pulse SHALL be 1 in the cycle after a boundary-event step, else 0.
REQ-028 clr_flags=1 clears both flags; if a boundary event occurs the same cycle, that event's flag SHALL be set (set wins) and the other cleared.
REQ-029 up_down and en changes SHALL take effect on the next rising edge; no combinational input-to-output paths.

Reset
REQ-030 reset=0 SHALL asynchronously force counter=0, bound_pulse=0, ovf_flag=0, udf_flag=0, independent of clk.
REQ-031 reset asserted mid-count SHALL discard any pending step/load; first edge after deassertion with en=1 operates from counter=0.
REQ-032 Outputs SHALL remain at reset values while reset=0, regardless of load, en, clr_flags.

Verification
REQ-033 WIDTH=4, MAX_VAL=9, STEP=1, SATURATE=0; reset released, en=1, up_down=1 for 12 cycles -> 1..9,0,1,2; bound_pulse high one cycle after the 9->0 step; ovf_flag=1.
REQ-034 Same params; from 0, up_down=0, en=1 -> counter=9, udf_flag=1, bound_pulse one cycle; clr_flags=1 next cycle -> udf_flag=0.
REQ-035 WIDTH=4, MAX_VAL=15, STEP=3, SATURATE=1; load_val=13 then up step -> 15, ovf_flag=1; further up steps -> holds 15, bound_pulse high each cycle; down steps from 2 -> 0.
REQ-036 WIDTH=8 defaults; load=1, en=1, up_down=1, load_val=200 -> counter=200, no flags; load_val=255 with MAX_VAL=100 -> counter=100.
REQ-037 Counting up at counter=5, reset pulsed low between clock edges -> counter=0 immediately; after release, counts 1,2,... with flags 0.
REQ-038 At counter=MAX_VAL (wrap), en=1, up_down=1, clr_flags=1 with udf_flag=1, ovf_flag=0 -> ovf_flag=1, udf_flag=0, counter=0.
